lvds_word_align: RTL and testbench
==================================

LVDS_WORD_ALIGN -- requirements
Module: lvds_word_align

Interface
REQ-001 The block SHALL provide parameter TRAIN_PATTERN, default 7'b1100011, expected per-lane training word.
REQ-002 The block SHALL provide parameter MATCH_COUNT, default 64, consecutive matches needed to lock a lane.
REQ-003 The block SHALL provide parameter SETTLE_CYCLES, default 16, wait after any slip or start before comparing.
REQ-004 The block SHALL provide parameter MAX_SLIP, default 14, slips allowed per lane before failure.
REQ-005 The block SHALL provide parameter LOSS_THRESHOLD, default 4, consecutive mismatches that drop a locked lane (monitor only).
REQ-006 The block SHALL have port clk, input, 1, deserializer slow/output clock; sole clock.
REQ-007 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have port rx_data, input, 56, deserialized words; lane i = bits [7i+6:7i].
REQ-009 The block SHALL have port rx_locked, input, 1, deserializer PLL lock.
REQ-010 The block SHALL have port train_en, input, 1, link partner transmitting TRAIN_PATTERN.
REQ-011 The block SHALL have port realign, input, 1, single-cycle request to retrain all lanes.
REQ-012 The block SHALL have port rx_channel_data_align, output, 8, per-lane bit-slip pulse to deserializer.
REQ-013 The block SHALL have ports lane_locked (output, 8), aligned (output, 1, registered &lane_locked), align_error (output, 1, registered OR of failed lanes).

Function
REQ-014 Each lane SHALL run an independent FSM: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.
REQ-015 IDLE -> SETTLE when rx_locked=1 and train_en=1; settle counter and slip counter cleared.
REQ-016 SETTLE SHALL count SETTLE_CYCLES clocks, then enter CHECK with match counter cleared.
REQ-017 CHECK: lane word == TRAIN_PATTERN increments match counter; reaching MATCH_COUNT -> LOCKED.
REQ-018 CHECK mismatch: slip counter < MAX_SLIP -> SLIP; otherwise -> FAIL.
REQ-019 SLIP SHALL drive rx_channel_data_align[i]=1 for exactly one clock, increment slip counter, go to SETTLE; pulses on a lane are therefore separated by >= SETTLE_CYCLES+1 low cycles.
REQ-020 LOCKED SHALL hold lane_locked[i]=1 regardless of train_en.
REQ-021 FAIL SHALL hold the lane's error flag until train_en=0, then return to IDLE.
REQ-022 train_en=0 in SETTLE, CHECK or SLIP SHALL return the lane to IDLE without issuing a pulse.
REQ-023 realign=1 SHALL send every non-IDLE lane to SETTLE with all counters and lane_locked cleared.
REQ-024 rx_locked=0 SHALL force every lane to IDLE next cycle, overriding all other events, clearing all outputs.
REQ-025 Priority per cycle: rx_locked loss > realign > train_en loss > FSM transition.
REQ-026 Counters SHALL saturate, never wrap; widths sized by $clog2 of their parameter plus one.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all FSMs to IDLE and all counters to 0.
REQ-028 During and after reset, until FSM activity, rx_channel_data_align=0, lane_locked=0, aligned=0, align_error=0.

Configuration
REQ-029 With LVDS_ALIGN_MONITOR_EN defined, LOCKED with train_en=1 SHALL count consecutive mismatches and, on LOSS_THRESHOLD, clear lane_locked[i] and go to SETTLE with slip counter cleared; any match clears the count.
REQ-030 Without LVDS_ALIGN_MONITOR_EN, LOCKED SHALL exit only on rx_locked=0, realign or reset; no monitor logic synthesized.

Verification
REQ-031 All lanes already aligned, rx_locked=1, train_en=1 -> no pulses; lane_locked=8'hFF 16+64 cycles later; aligned=1 one cycle after.
REQ-032 Lane 3 rotated by 2 bits (deserializer model slips one bit per pulse) -> exactly two pulses on bit 3, >=17 cycles apart; lane 3 locks; other lanes unaffected.
REQ-033 Lane 5 constant 7'h00 -> 14 pulses on bit 5, then align_error=1, lane_locked[5]=0, aligned=0; train_en=0 -> align_error=0 next cycle.
REQ-034 rx_locked dropped on the cycle a SLIP would pulse -> no pulse; all outputs 0 next cycle; retraining from IDLE after rx_locked returns.
REQ-035 After aligned=1, inject 4 consecutive mismatches on lane 0 with train_en=1 -> lane_locked[0]=0 and aligned=0 with LVDS_ALIGN_MONITOR_EN; both stay 1 without it.
REQ-036 One mismatch at match 63 in CHECK -> one slip pulse, match counter restarts; lock no earlier than 17+64 further cycles.

Source files
------------

// File: rtl/lvds_word_align.sv
// Per-lane word aligner for an 8-lane LVDS deserializer: bit-slips each lane until
// TRAIN_PATTERN is seen MATCH_COUNT times in a row. Optional lock monitor: LVDS_ALIGN_MONITOR_EN.
module lvds_word_align #(
   parameter logic [6:0] TRAIN_PATTERN  = 7'b1100011,
   parameter int         MATCH_COUNT    = 64,
   parameter int         SETTLE_CYCLES  = 16,
   parameter int         MAX_SLIP       = 14,
   parameter int         LOSS_THRESHOLD = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [55:0] rx_data,
   input  logic        rx_locked,
   input  logic        train_en,
   input  logic        realign,
   output logic [7:0]  rx_channel_data_align,
   output logic [7:0]  lane_locked,
   output logic        aligned,
   output logic        align_error,
   output logic [23:0] lane_state_dbg
);

   localparam int SW = $clog2(SETTLE_CYCLES) + 1;
   localparam int MW = $clog2(MATCH_COUNT) + 1;
   localparam int PW = $clog2(MAX_SLIP) + 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
   localparam logic [MW-1:0] MATCH_SAT   = MW'(MATCH_COUNT);
   localparam logic [PW-1:0] SLIP_MAX    = PW'(MAX_SLIP);
`ifdef LVDS_ALIGN_MONITOR_EN
   localparam int LW = $clog2(LOSS_THRESHOLD) + 1;
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_THRESHOLD - 1);
`endif

   typedef enum logic [2:0] {
      ST_IDLE, ST_SETTLE, ST_CHECK, ST_SLIP, ST_LOCKED, ST_FAIL
   } state_t;

   logic [7:0] fail_next;

   for (genvar i = 0; i < 8; i++) begin : g_lane
      state_t          state_q, state_d;
      logic [SW-1:0]   settle_q, settle_d;
      logic [MW-1:0]   match_q, match_d;
      logic [PW-1:0]   slip_q, slip_d;
      logic            word_ok, clr, slip_pulse;
`ifdef LVDS_ALIGN_MONITOR_EN
      logic [LW-1:0]   loss_q, loss_d;
`endif

      assign word_ok = (rx_data[7*i +: 7] == TRAIN_PATTERN);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            match_q  <= '0;
            slip_q   <= '0;
`ifdef LVDS_ALIGN_MONITOR_EN
            loss_q   <= '0;
`endif
         end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            match_q  <= match_d;
            slip_q   <= slip_d;
`ifdef LVDS_ALIGN_MONITOR_EN
            loss_q   <= loss_d;
`endif
         end
      end

      // Global events first (PLL loss > realign > training loss), then the lane's own transition.
      always_comb begin
         state_d    = state_q;
         settle_d   = settle_q;
         match_d    = match_q;
         slip_d     = slip_q;
         slip_pulse = 1'b0;
         clr        = 1'b0;
`ifdef LVDS_ALIGN_MONITOR_EN
         loss_d     = loss_q;
`endif
         if (!rx_locked) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
         end else if (realign && state_q != ST_IDLE) begin
            state_d = ST_SETTLE;
            clr     = 1'b1;
         end else if (!train_en && state_q inside {ST_SETTLE, ST_CHECK, ST_SLIP, ST_FAIL}) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (train_en) begin
                     state_d = ST_SETTLE;
                     clr     = 1'b1;
                  end
               end
               ST_SETTLE: begin
                  if (settle_q >= SETTLE_LAST) begin
                     state_d = ST_CHECK;
                     match_d = '0;
                  end else begin
                     settle_d = settle_q + 1'b1;
                  end
               end
               ST_CHECK: begin
                  if (word_ok) begin
                     if (match_q >= MATCH_LAST) begin
                        state_d = ST_LOCKED;
                        match_d = MATCH_SAT;
                     end else begin
                        match_d = match_q + 1'b1;
                     end
                  end else if (slip_q < SLIP_MAX) begin
                     state_d = ST_SLIP;
                  end else begin
                     state_d = ST_FAIL;
                  end
               end
               ST_SLIP: begin
                  slip_pulse = 1'b1;
                  slip_d     = (slip_q < SLIP_MAX) ? slip_q + 1'b1 : slip_q;
                  settle_d   = '0;
                  state_d    = ST_SETTLE;
               end
`ifdef LVDS_ALIGN_MONITOR_EN
               ST_LOCKED: begin
                  if (train_en) begin
                     if (word_ok) begin
                        loss_d = '0;
                     end else if (loss_q >= LOSS_LAST) begin
                        state_d = ST_SETTLE;
                        clr     = 1'b1;
                     end else begin
                        loss_d = loss_q + 1'b1;
                     end
                  end
               end
`else
               ST_LOCKED: ;
`endif
               ST_FAIL: ;
               default: state_d = ST_IDLE;
            endcase
         end
         if (clr) begin
            settle_d = '0;
            match_d  = '0;
            slip_d   = '0;
`ifdef LVDS_ALIGN_MONITOR_EN
            loss_d   = '0;
`endif
         end
      end

      assign rx_channel_data_align[i] = slip_pulse;
      assign lane_locked[i]           = (state_q == ST_LOCKED);
      assign fail_next[i]             = (state_d == ST_FAIL);
      assign lane_state_dbg[3*i +: 3] = state_q;
   end

   // Summary flags clear on the same edge that sends the lanes to IDLE/SETTLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aligned     <= 1'b0;
         align_error <= 1'b0;
      end else begin
         aligned     <= rx_locked & ~realign & (&lane_locked);
         align_error <= |fail_next;
      end
   end

endmodule

// File: tb/tb_lvds_word_align.sv
// Directed bench for lvds_word_align with a bit-slipping deserializer model per lane.
// Build with +define+LVDS_ALIGN_MONITOR_EN to check the lock-monitor variant.
module tb_lvds_word_align;

   localparam logic [6:0] TP = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [55:0] rx_data;
   logic        rx_locked, train_en, realign;
   logic [7:0]  rx_channel_data_align, lane_locked;
   logic        aligned, align_error;
   logic [23:0] lane_state_dbg;

   int          n_err = 0;
   int          n_chk = 0;
   int          cyc;
   int          rot[8];
   logic        force_en[8];
   logic [6:0]  force_val[8];
   bit          slip_model_en = 1'b1;
   int          pulse_cnt[8];
   int          last_pulse[8];
   int          min_gap[8];

   lvds_word_align dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .rx_data               (rx_data),
      .rx_locked             (rx_locked),
      .train_en              (train_en),
      .realign               (realign),
      .rx_channel_data_align (rx_channel_data_align),
      .lane_locked           (lane_locked),
      .aligned               (aligned),
      .align_error           (align_error),
      .lane_state_dbg        (lane_state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] rotl(input logic [6:0] w, input int n);
      logic [6:0] r;
      r = w;
      for (int k = 0; k < n; k++) r = {r[5:0], r[6]};
      return r;
   endfunction

   task automatic drive_data();
      for (int i = 0; i < 8; i++)
         rx_data[7*i +: 7] = force_en[i] ? force_val[i] : rotl(TP, rot[i]);
   endtask

   task automatic clear_stats();
      cyc = 0;
      for (int i = 0; i < 8; i++) begin
         pulse_cnt[i] = 0; last_pulse[i] = -1; min_gap[i] = 1000;
      end
   endtask

   // One clock: pulses are sampled mid-cycle, the model slips on the following edge.
   task automatic step();
      logic [7:0] p;
      @(negedge clk);
      p = rx_channel_data_align;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 8; i++) begin
         if (p[i]) begin
            pulse_cnt[i]++;
            if (last_pulse[i] >= 0 && cyc - last_pulse[i] < min_gap[i]) min_gap[i] = cyc - last_pulse[i];
            last_pulse[i] = cyc;
            if (slip_model_en) rot[i] = (rot[i] + 6) % 7;
         end
      end
      drive_data();
   endtask

   task automatic go_idle();
      rx_locked = 1'b0; train_en = 1'b0; realign = 1'b0;
      for (int i = 0; i < 8; i++) begin rot[i] = 0; force_en[i] = 1'b0; force_val[i] = 7'h00; end
      drive_data();
      step();
      rx_locked = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rx_locked = 1'b1; train_en = 1'b1; realign = 1'b0;
      for (int i = 0; i < 8; i++) begin rot[i] = 0; force_en[i] = 1'b0; force_val[i] = 7'h00; end
      drive_data();
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (rx_channel_data_align !== 8'h00) begin n_err++; $display("FAIL reset_pulse: got %h expected 00", rx_channel_data_align); end
      n_chk++; if (lane_locked !== 8'h00) begin n_err++; $display("FAIL reset_locked: got %h expected 00", lane_locked); end
      n_chk++; if (aligned !== 1'b0) begin n_err++; $display("FAIL reset_aligned: got %b expected 0", aligned); end
      n_chk++; if (align_error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b expected 0", align_error); end
      n_chk++; if (lane_state_dbg !== 24'h0) begin n_err++; $display("FAIL reset_state: got %h expected 000000", lane_state_dbg); end
      rx_locked = 1'b0; train_en = 1'b0;
      rst_n = 1'b1;
      step();
      rx_locked = 1'b1;
   endtask

   task automatic test_all_aligned();
      int tot;
      clear_stats();
      train_en = 1'b1;
      for (int k = 0; k < 200; k++) begin
         step();
         if (lane_locked === 8'hFF) break;
      end
      n_chk++; if (cyc !== 81) begin n_err++; $display("FAIL all_lock_time: got %0d expected 81", cyc); end
      step();
      n_chk++; if (aligned !== 1'b1) begin n_err++; $display("FAIL all_aligned: got %b expected 1", aligned); end
      tot = 0;
      for (int i = 0; i < 8; i++) tot += pulse_cnt[i];
      n_chk++; if (tot !== 0) begin n_err++; $display("FAIL all_no_pulses: got %0d expected 0", tot); end
      n_chk++; if (align_error !== 1'b0) begin n_err++; $display("FAIL all_error: got %b expected 0", align_error); end
   endtask

   task automatic test_realign();
      clear_stats();
      realign = 1'b1;
      step();
      realign = 1'b0;
      n_chk++; if (lane_locked !== 8'h00) begin n_err++; $display("FAIL realign_clear: got %h expected 00", lane_locked); end
      n_chk++; if (aligned !== 1'b0) begin n_err++; $display("FAIL realign_aligned: got %b expected 0", aligned); end
      for (int k = 0; k < 200; k++) begin
         step();
         if (lane_locked === 8'hFF) break;
      end
      n_chk++; if (cyc !== 81) begin n_err++; $display("FAIL realign_relock: got %0d expected 81", cyc); end
   endtask

   task automatic test_slip_lane3();
      int others;
      go_idle();
      rot[3] = 2;
      drive_data();
      clear_stats();
      train_en = 1'b1;
      for (int k = 0; k < 300; k++) begin
         step();
         if (cyc == 81) begin
            n_chk++; if (lane_locked !== 8'hF7) begin n_err++; $display("FAIL slip3_others: got %h expected f7", lane_locked); end
         end
         if (lane_locked === 8'hFF) break;
      end
      n_chk++; if (cyc !== 117) begin n_err++; $display("FAIL slip3_lock_time: got %0d expected 117", cyc); end
      n_chk++; if (pulse_cnt[3] !== 2) begin n_err++; $display("FAIL slip3_pulses: got %0d expected 2", pulse_cnt[3]); end
      n_chk++; if (min_gap[3] !== 18) begin n_err++; $display("FAIL slip3_gap: got %0d expected 18", min_gap[3]); end
      others = 0;
      for (int i = 0; i < 8; i++) if (i != 3) others += pulse_cnt[i];
      n_chk++; if (others !== 0) begin n_err++; $display("FAIL slip3_other_pulses: got %0d expected 0", others); end
   endtask

   task automatic test_fail_lane5();
      go_idle();
      force_en[5] = 1'b1; force_val[5] = 7'h00;
      drive_data();
      clear_stats();
      train_en = 1'b1;
      for (int k = 0; k < 600; k++) begin
         step();
         if (align_error === 1'b1) break;
      end
      n_chk++; if (cyc !== 270) begin n_err++; $display("FAIL fail5_time: got %0d expected 270", cyc); end
      n_chk++; if (pulse_cnt[5] !== 14) begin n_err++; $display("FAIL fail5_pulses: got %0d expected 14", pulse_cnt[5]); end
      n_chk++; if (lane_locked !== 8'hDF) begin n_err++; $display("FAIL fail5_locked: got %h expected df", lane_locked); end
      step();
      n_chk++; if (aligned !== 1'b0) begin n_err++; $display("FAIL fail5_aligned: got %b expected 0", aligned); end
      n_chk++; if (align_error !== 1'b1) begin n_err++; $display("FAIL fail5_error_hold: got %b expected 1", align_error); end
      train_en = 1'b0;
      step();
      n_chk++; if (align_error !== 1'b0) begin n_err++; $display("FAIL fail5_error_clear: got %b expected 0", align_error); end
      n_chk++; if (lane_locked !== 8'hDF) begin n_err++; $display("FAIL fail5_locked_hold: got %h expected df", lane_locked); end
   endtask

   task automatic test_loss_of_lock();
      go_idle();
      rot[3] = 2;
      drive_data();
      clear_stats();
      train_en = 1'b1;
      repeat (18) step();
      n_chk++; if (rx_channel_data_align !== 8'h08) begin n_err++; $display("FAIL lol_slip_state: got %h expected 08", rx_channel_data_align); end
      rx_locked = 1'b0;
      #1;
      n_chk++; if (rx_channel_data_align !== 8'h00) begin n_err++; $display("FAIL lol_no_pulse: got %h expected 00", rx_channel_data_align); end
      step();
      n_chk++; if (pulse_cnt[3] !== 0) begin n_err++; $display("FAIL lol_pulse_count: got %0d expected 0", pulse_cnt[3]); end
      n_chk++; if (lane_locked !== 8'h00 || aligned !== 1'b0 || align_error !== 1'b0) begin
         n_err++; $display("FAIL lol_outputs: got %h/%b/%b expected 00/0/0", lane_locked, aligned, align_error);
      end
      n_chk++; if (lane_state_dbg !== 24'h0) begin n_err++; $display("FAIL lol_idle: got %h expected 000000", lane_state_dbg); end
      rx_locked = 1'b1;
      clear_stats();
      for (int k = 0; k < 300; k++) begin
         step();
         if (lane_locked === 8'hFF) break;
      end
      n_chk++; if (cyc !== 117) begin n_err++; $display("FAIL lol_retrain: got %0d expected 117", cyc); end
      n_chk++; if (pulse_cnt[3] !== 2) begin n_err++; $display("FAIL lol_retrain_pulses: got %0d expected 2", pulse_cnt[3]); end
   endtask

   task automatic test_mismatch_at_63();
      go_idle();
      slip_model_en = 1'b0;
      clear_stats();
      train_en = 1'b1;
      repeat (80) step();
      force_en[0] = 1'b1; force_val[0] = ~TP;
      drive_data();
      step();
      force_en[0] = 1'b0;
      drive_data();
      n_chk++; if (lane_locked !== 8'hFE) begin n_err++; $display("FAIL m63_others: got %h expected fe", lane_locked); end
      for (int k = 0; k < 300; k++) begin
         step();
         if (lane_locked === 8'hFF) break;
      end
      n_chk++; if (cyc !== 162) begin n_err++; $display("FAIL m63_relock: got %0d expected 162", cyc); end
      n_chk++; if (pulse_cnt[0] !== 1) begin n_err++; $display("FAIL m63_pulses: got %0d expected 1", pulse_cnt[0]); end
      slip_model_en = 1'b1;
   endtask

   task automatic test_monitor();
      logic [7:0] exp_ll;
      logic       exp_al;
      step();
      n_chk++; if (aligned !== 1'b1) begin n_err++; $display("FAIL mon_pre_aligned: got %b expected 1", aligned); end
      force_en[0] = 1'b1; force_val[0] = 7'h00;
      drive_data();
      repeat (3) step();
      force_en[0] = 1'b0;
      drive_data();
      repeat (2) step();
      n_chk++; if (lane_locked !== 8'hFF || aligned !== 1'b1) begin
         n_err++; $display("FAIL mon_three_miss: got %h/%b expected ff/1", lane_locked, aligned);
      end
      force_en[0] = 1'b1;
      drive_data();
      repeat (4) step();
      force_en[0] = 1'b0;
      drive_data();
      step();
`ifdef LVDS_ALIGN_MONITOR_EN
      exp_ll = 8'hFE; exp_al = 1'b0;
`else
      exp_ll = 8'hFF; exp_al = 1'b1;
`endif
      n_chk++; if (lane_locked !== exp_ll) begin n_err++; $display("FAIL mon_locked: got %h expected %h", lane_locked, exp_ll); end
      n_chk++; if (aligned !== exp_al) begin n_err++; $display("FAIL mon_aligned: got %b expected %b", aligned, exp_al); end
   endtask

   initial begin
      test_reset();
      test_all_aligned();
      test_realign();
      test_slip_lane3();
      test_fail_lane5();
      test_loss_of_lock();
      test_mismatch_at_63();
      test_monitor();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
